// File: rtl/sumador_serie_pkg.sv
// sumador_serie_pkg: shared types and helpers for the digit-serial adder.
//   state_e : controller states, 2-bit encoded.
//   clog2   : ceil(log2(n)) with a floor of 1, used to size the digit counter.
package sumador_serie_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sumador_serie_digito.sv
// sumador_digito: combinational DIGIT-bit ripple adder built from an array
// of 1-bit full-adder cells (sumador_fa).
//   a, b  [DIGIT] : operand digits
//   ci            : carry into bit 0
//   s     [DIGIT] : sum digit
//   co            : carry out of the top bit
//   c_msb         : carry into the top bit (feeds signed-overflow detection)

module sumador_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module sumador_digito #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);
  // w_c[i] is the carry into cell i; w_c[DIGIT] leaves the digit.
  logic [DIGIT:0] w_c;

  assign w_c[0] = ci;

  sumador_fa u_fa [DIGIT-1:0] (
    .a  (a),
    .b  (b),
    .ci (w_c[DIGIT-1:0]),
    .s  (s),
    .co (w_c[DIGIT:1])
  );

  assign co    = w_c[DIGIT];
  assign c_msb = w_c[DIGIT-1];
endmodule

// File: rtl/sumador_serie.sv
// sumador_serie: digit-serial adder. {Cout,S} = A + B + Ci computed DIGIT bits
// per clock over N = WIDTH/DIGIT cycles with a registered inter-digit carry.
//   clk, rst (sync, active-high)
//   start       : request; sampled only in IDLE or DONE
//   A, B, Ci    : operands, captured on the accepting edge
//   busy        : digits in flight (RUN)
//   done        : one-cycle pulse, S/Cout valid
//   S, Cout     : result, held until the next accepted start
//   ovf         : signed overflow, only when SUMADOR_SERIE_OVF_EN is defined

module sumador_serie
  import sumador_serie_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef SUMADOR_SERIE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int             N    = WIDTH / DIGIT;
  localparam int             CW   = clog2(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("sumador_serie: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  state_e            r_state, w_next;
  logic [WIDTH-1:0]  r_a_sh, r_b_sh, r_res, r_s;
  logic              r_carry, r_cout;
  logic [CW-1:0]     r_cnt;

  logic [DIGIT-1:0]  w_sum;
  logic              w_co, w_c_msb;
  logic              w_accept, w_run, w_last;
  logic [WIDTH-1:0]  w_res_next;

  sumador_digito #(.DIGIT(DIGIT)) u_dig (
    .a     (r_a_sh[DIGIT-1:0]),
    .b     (r_b_sh[DIGIT-1:0]),
    .ci    (r_carry),
    .s     (w_sum),
    .co    (w_co),
    .c_msb (w_c_msb)
  );

  // New digit enters at the MSB end; after N steps digit 0 lands at the LSBs.
  assign w_res_next = WIDTH'({w_sum, r_res} >> DIGIT);

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_run    = 1'b0;
    w_last   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_accept = start;
        if (start) w_next = RUN;
      end
      RUN: begin
        w_run  = 1'b1;
        w_last = (r_cnt == LAST);
        if (r_cnt == LAST) w_next = DONE;
      end
      DONE: begin
        w_accept = start;
        w_next   = start ? RUN : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a_sh  <= A;
        r_b_sh  <= B;
        r_carry <= Ci;
        r_cnt   <= '0;
        r_res   <= '0;
      end else if (w_run) begin
        r_a_sh  <= r_a_sh >> DIGIT;
        r_b_sh  <= r_b_sh >> DIGIT;
        r_carry <= w_co;
        r_cnt   <= r_cnt + 1'b1;
        r_res   <= w_res_next;
      end
      // Only the finished result is published; partial sums stay internal.
      if (w_last) begin
        r_s    <= w_res_next;
        r_cout <= w_co;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign S    = r_s;
  assign Cout = r_cout;

`ifdef SUMADOR_SERIE_OVF_EN
  logic r_ovf;
  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk) begin
    if (rst)         r_ovf <= 1'b0;
    else if (w_last) r_ovf <= w_c_msb ^ w_co;
  end
  assign ovf = r_ovf;
`else
  logic w_unused_cmsb;
  assign w_unused_cmsb = w_c_msb;
`endif

endmodule

// File: tb/tb_sumador_serie.sv
module tb_sumador_serie;

  localparam int NC = 5;
  localparam int WS [NC] = '{8, 8, 8, 8, 16};
  localparam int DS [NC] = '{1, 2, 4, 8, 4};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NC-1:0]       st    = '0;
  logic [NC-1:0]       ci_in = '0;
  logic [NC-1:0][15:0] a_in  = '0;
  logic [NC-1:0][15:0] b_in  = '0;
  logic [NC-1:0]       busy_o, done_o, cout_o;
  logic [NC-1:0][15:0] s_o;
`ifdef SUMADOR_SERIE_OVF_EN
  logic [NC-1:0]       ovf_o;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NC; g++) begin : g_dut
    localparam int W = WS[g];
    localparam int D = DS[g];
    logic [W-1:0] w_s;
    sumador_serie #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (st[g]),
      .A     (a_in[g][W-1:0]),
      .B     (b_in[g][W-1:0]),
      .Ci    (ci_in[g]),
      .busy  (busy_o[g]),
      .done  (done_o[g]),
      .S     (w_s),
      .Cout  (cout_o[g])
`ifdef SUMADOR_SERIE_OVF_EN
      ,
      .ovf   (ovf_o[g])
`endif
    );
    assign s_o[g] = 16'(w_s);
  end

  // ---------------- reference model ----------------
  function automatic int mask(input int w);
    return (1 << w) - 1;
  endfunction

  function automatic int ref_sum(input int g);
    return (int'(a_in[g]) & mask(WS[g])) + (int'(b_in[g]) & mask(WS[g])) + int'(ci_in[g]);
  endfunction

  // Overflow from the signed interpretation of the operands.
  function automatic bit ref_ovf(input int g);
    int w, a, b, s;
    w = WS[g];
    a = int'(a_in[g]) & mask(w);
    b = int'(b_in[g]) & mask(w);
    if (a >= (1 << (w - 1))) a = a - (1 << w);
    if (b >= (1 << (w - 1))) b = b - (1 << w);
    s = a + b + int'(ci_in[g]);
    return (s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)));
  endfunction

  int m_left  [NC] = '{default: 0};   // cycles until result, 0 = free to accept
  int m_pend  [NC] = '{default: 0};
  int m_held  [NC] = '{default: 0};   // {Cout,S} as one integer
  bit m_pov   [NC] = '{default: 0};
  bit m_hov   [NC] = '{default: 0};
  bit m_done  [NC] = '{default: 0};
  int m_ndone [NC] = '{default: 0};

  always @(posedge clk) begin
    for (int g = 0; g < NC; g++) begin
      if (rst) begin
        m_left[g] <= 0;
        m_held[g] <= 0;
        m_hov[g]  <= 1'b0;
        m_done[g] <= 1'b0;
      end else if (m_left[g] != 0) begin
        m_left[g] <= m_left[g] - 1;
        m_done[g] <= (m_left[g] == 1);
        if (m_left[g] == 1) begin
          m_held[g]  <= m_pend[g];
          m_hov[g]   <= m_pov[g];
          m_ndone[g] <= m_ndone[g] + 1;
        end
      end else begin
        m_done[g] <= 1'b0;
        if (st[g]) begin
          m_left[g] <= WS[g] / DS[g];
          m_pend[g] <= ref_sum(g);
          m_pov[g]  <= ref_ovf(g);
        end
      end
    end
  end

  // ---------------- every-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < NC; g++) begin
        int es, ec;
        bit eb, ed, bad;
        es  = m_held[g] & mask(WS[g]);
        ec  = (m_held[g] >> WS[g]) & 1;
        eb  = (m_left[g] != 0);
        ed  = m_done[g];
        bad = (busy_o[g] !== eb) || (done_o[g] !== ed) ||
              (cout_o[g] !== 1'(ec)) || (s_o[g] !== 16'(es));
`ifdef SUMADOR_SERIE_OVF_EN
        bad = bad || (ovf_o[g] !== m_hov[g]);
`endif
        n_cmp++;
        if (bad) begin
          n_err++;
          $display("FAIL cycle dut%0d @%0d: busy/done/Cout/S got %b/%b/%b/%h want %b/%b/%0d/%h",
                   g, cyc, busy_o[g], done_o[g], cout_o[g], s_o[g], eb, ed, ec, es);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input int g, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, output int res, output int lat, output int bcnt);
    @(negedge clk);
    st[g] = 1'b1; a_in[g] = a; b_in[g] = b; ci_in[g] = ci;
    @(negedge clk);
    st[g] = 1'b0;
    a_in[g] = 16'($urandom);  // operands may change during RUN
    b_in[g] = 16'($urandom);
    lat = 0; bcnt = 0;
    while (!done_o[g] && lat < 100) begin
      if (busy_o[g]) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL timeout dut%0d: no done within 100 cycles", g);
    end
    res = (int'(cout_o[g]) << WS[g]) | int'(s_o[g]);
  endtask

  task automatic rand_run(input int g, input int nops);
    int target, lim;
    target = m_ndone[g] + nops;
    lim = 0;
    while (m_ndone[g] < target && lim < 30000) begin
      @(negedge clk);
      st[g] = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       a_in[g] = 16'hFFFF;
        1:       a_in[g] = 16'h0000;
        2:       a_in[g] = 16'h7FFF >> (16 - WS[g]);
        default: a_in[g] = 16'($urandom);
      endcase
      b_in[g]  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      ci_in[g] = 1'($urandom);
      lim++;
    end
    st[g] = 1'b0;
    if (lim >= 30000) begin
      n_cmp++; n_err++;
      $display("FAIL random dut%0d: only %0d of %0d ops finished", g, nops - (target - m_ndone[g]), nops);
    end
    repeat (20) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int res, lat, bc, t1, t2, s1, s2, k, nd;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int g = 0; g < NC; g++) begin
      chk($sformatf("reset_busy%0d", g), 32'(busy_o[g]), 0);
      chk($sformatf("reset_done%0d", g), 32'(done_o[g]), 0);
      chk($sformatf("reset_SC%0d", g), {15'd0, cout_o[g], s_o[g]}, 0);
    end
    rst = 1'b0;
    chk_en = 1'b1;

    // 8/1: 3C + 0F
    run_op(0, 16'h3C, 16'h0F, 1'b0, res, lat, bc);
    chk("t1_sum", 32'(res), 32'h04B);
    chk("t1_latency", 32'(lat), 8);
    chk("t1_busy_cycles", 32'(bc), 8);
    chk("t1_model", 32'(m_held[0]), 32'h04B);

    // 8/4: FF + 01 + 1
    run_op(2, 16'hFF, 16'h01, 1'b1, res, lat, bc);
    chk("t2_sum", 32'(res), 32'h101);
    chk("t2_latency", 32'(lat), 2);
    chk("t2_model_ovf", 32'(m_hov[2]), 0);
`ifdef SUMADOR_SERIE_OVF_EN
    chk("t2_ovf", 32'(ovf_o[2]), 0);
`endif

    // 8/1: 7F + 01 -> signed overflow
    run_op(0, 16'h7F, 16'h01, 1'b0, res, lat, bc);
    chk("t3_sum", 32'(res), 32'h080);
    chk("t3_model_ovf", 32'(m_hov[0]), 1);
`ifdef SUMADOR_SERIE_OVF_EN
    chk("t3_ovf", 32'(ovf_o[0]), 1);
`endif

    // back-to-back with start held high
    @(negedge clk);
    st[0] = 1'b1; a_in[0] = 16'h01; b_in[0] = 16'h02; ci_in[0] = 1'b0;
    @(negedge clk);
    a_in[0] = 16'h10; b_in[0] = 16'h20;
    k = 0;
    while (!done_o[0] && k < 50) begin @(negedge clk); k++; end
    t1 = cyc; s1 = int'(s_o[0]);
    @(negedge clk);
    st[0] = 1'b0;
    k = 0;
    while (!done_o[0] && k < 50) begin @(negedge clk); k++; end
    t2 = cyc; s2 = int'(s_o[0]);
    chk("b2b_S1", 32'(s1), 32'h03);
    chk("b2b_S2", 32'(s2), 32'h30);
    chk("b2b_spacing", 32'(t2 - t1), 9);

    // reset on the 4th RUN cycle aborts
    @(negedge clk);
    st[0] = 1'b1; a_in[0] = 16'h11; b_in[0] = 16'h22;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy_o[0]), 0);
    chk("abort_done", 32'(done_o[0]), 0);
    chk("abort_SC", {15'd0, cout_o[0], s_o[0]}, 0);
    nd = 0;
    repeat (10) begin @(negedge clk); if (done_o[0]) nd++; end
    chk("abort_no_done", 32'(nd), 0);
    run_op(0, 16'hAA, 16'h55, 1'b0, res, lat, bc);
    chk("after_abort_sum", 32'(res), 32'h0FF);

    // randomized operations for every configuration
    for (int g = 0; g < NC; g++) rand_run(g, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
